// File: rtl/i2s_record_writer.sv
// I2S capture path: deserialises left/right PCM slots, buffers them in a small FIFO,
// and writes each sample to SDRAM at sequential word addresses via a command/finished handshake.
module i2s_record_writer #(
  parameter int SAMPLE_W   = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 25,
  parameter int BASE_ADDR  = 0,
  parameter int MEM_WORDS  = 2**22
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Record,
  input  logic                BClk,
  input  logic                LRClk,
  input  logic                I2SIn,
  output logic                write_command,
  output logic [ADDR_W-1:0]   write_address,
  output logic [SAMPLE_W-1:0] write_data,
  input  logic                write_finished,
  output logic                Busy,
  output logic                Overflow,
  output logic                MemFull,
  output logic                state_dbg_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(BASE_ADDR + MEM_WORDS - 1);
  localparam logic [4:0]        LAST_BIT = 5'(SAMPLE_W);
  localparam logic [PW:0]       DEPTH    = (PW+1)'(FIFO_DEPTH);

  typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_e;

  // Handshake: write_command rises with address/data already valid, all three stay stable
  // until the one-cycle write_finished pulse; command then drops for at least one cycle.
  logic [1:0]          bclk_sync_q, lr_sync_q, din_sync_q;
  logic                bclk_prev_q;
  logic                lr_prev_q, lr_prev_d;
  logic [4:0]          bitcnt_q, bitcnt_d;
  logic [SAMPLE_W-1:0] shift_q, shift_d;
  logic                armed_q, armed_d;
  logic                record_prev_q;
  logic [SAMPLE_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [PW:0]         count_q;
  state_e              state_q;
  logic                cmd_q, overflow_q, memfull_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [SAMPLE_W-1:0] data_q;

  logic                strobe, lr_s, din_s, push, push_ok, pop, flush, fifo_full, busy, rec_rise;
  logic [SAMPLE_W-1:0] push_data;

  assign strobe    = bclk_sync_q[1] & ~bclk_prev_q;
  assign lr_s      = lr_sync_q[1];
  assign din_s     = din_sync_q[1];
  assign push_data = {shift_q[SAMPLE_W-2:0], din_s};
  assign pop       = (state_q == S_REQ) && write_finished;
  assign flush     = pop && (addr_q == LAST);
  assign fifo_full = (count_q == DEPTH);
  assign push_ok   = push && (!fifo_full || pop) && !flush;
  assign busy      = (count_q != '0) || (state_q == S_REQ);
  assign rec_rise  = Record && !record_prev_q;

  // Slot framing: bitcnt 0 is the strobe where LRClk changed, MSB arrives at bitcnt 1.
  always_comb begin
    lr_prev_d = lr_prev_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    armed_d   = armed_q;
    push      = 1'b0;
    if (strobe) begin
      lr_prev_d = lr_s;
      if (lr_s != lr_prev_q) begin
        bitcnt_d = 5'd0;
        if (!Record)
          armed_d = 1'b0;
        else if (lr_prev_q && !lr_s && !memfull_q)
          armed_d = 1'b1;
      end else begin
        if (bitcnt_q != 5'd31)
          bitcnt_d = bitcnt_q + 5'd1;
        if (bitcnt_d != 5'd0 && bitcnt_d <= LAST_BIT)
          shift_d = push_data;
        // Record must still be high, so a slot cut short by Record falling is discarded.
        if (bitcnt_d == LAST_BIT && bitcnt_q != LAST_BIT)
          push = armed_q && Record && !memfull_q;
      end
    end
    if (flush)
      armed_d = 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (push_ok)
      fifo_mem[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bclk_sync_q   <= '0;
      lr_sync_q     <= '0;
      din_sync_q    <= '0;
      bclk_prev_q   <= 1'b0;
      lr_prev_q     <= 1'b0;
      bitcnt_q      <= '0;
      shift_q       <= '0;
      armed_q       <= 1'b0;
      record_prev_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      state_q       <= S_IDLE;
      cmd_q         <= 1'b0;
      addr_q        <= BASE;
      data_q        <= '0;
      overflow_q    <= 1'b0;
      memfull_q     <= 1'b0;
    end else begin
      bclk_sync_q   <= {bclk_sync_q[0], BClk};
      lr_sync_q     <= {lr_sync_q[0], LRClk};
      din_sync_q    <= {din_sync_q[0], I2SIn};
      bclk_prev_q   <= bclk_sync_q[1];
      lr_prev_q     <= lr_prev_d;
      bitcnt_q      <= bitcnt_d;
      shift_q       <= shift_d;
      armed_q       <= armed_d;
      record_prev_q <= Record;

      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push_ok)
          wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)
          rd_ptr_q <= rd_ptr_q + PW'(1);
        count_q <= count_q + (PW+1)'(push_ok) - (PW+1)'(pop);
      end
      if (push && fifo_full && !pop)
        overflow_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (count_q != '0 && !memfull_q) begin
            state_q <= S_REQ;
            cmd_q   <= 1'b1;
            data_q  <= fifo_mem[rd_ptr_q];
          end
        end
        S_REQ: begin
          if (write_finished) begin
            state_q <= S_IDLE;
            cmd_q   <= 1'b0;
            if (addr_q == LAST)
              memfull_q <= 1'b1;
            else
              addr_q <= addr_q + ADDR_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // A new take only restarts when nothing from the previous one is still draining.
      if (rec_rise && !busy) begin
        addr_q     <= BASE;
        overflow_q <= 1'b0;
        memfull_q  <= 1'b0;
      end
    end
  end

  assign write_command = cmd_q;
  assign write_address = addr_q;
  assign write_data    = data_q;
  assign Busy          = busy;
  assign Overflow      = overflow_q;
  assign MemFull       = memfull_q;
  assign state_dbg_o   = state_q;

endmodule
